// File: rtl/mem_responder.sv
`timescale 1ns/1ps
// mem_responder: word-organised RAM target for the core's load/store/fetch port.
// Accepts one request at a time, steers store bytes into lanes, extracts and
// extends load data, and splits word-crossing accesses into two word accesses.
module mem_responder #(
  parameter int    DEPTH_WORDS = 4096,
  parameter int    WAIT_CYCLES = 0,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [32:0] MEM_BYTES = 33'(DEPTH_WORDS) << 2;
  localparam bit          HAS_WAIT  = (WAIT_CYCLES != 0);
  localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_ACC0 = 3'd2,
    S_ACC1 = 3'd3,
    S_RESP = 3'd4
  } state_e;

  // Number of bytes touched by an access, from size[1:0].
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      2'b00:   size_bytes = 3'd1;
      2'b01:   size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

  // Encodings that are never legal, plus unsigned sizes used with a store.
  function automatic logic size_illegal(input logic we, input logic [2:0] sz);
    case (sz)
      3'b000, 3'b001, 3'b010: size_illegal = 1'b0;
      3'b100, 3'b101:         size_illegal = we;
      default:                size_illegal = 1'b1;
    endcase
  endfunction

  // Picks the addressed bytes out of {hi,lo} and applies sign/zero extension.
  function automatic logic [31:0] load_result(input logic [31:0] hi, input logic [31:0] lo,
                                              input logic [1:0] off, input logic [2:0] sz);
    logic [31:0] raw;
    case (off)
      2'd0:    raw = lo;
      2'd1:    raw = {hi[7:0],  lo[31:8]};
      2'd2:    raw = {hi[15:0], lo[31:16]};
      default: raw = {hi[23:0], lo[31:24]};
    endcase
    case (sz)
      3'b000:  load_result = {{24{raw[7]}}, raw[7:0]};
      3'b001:  load_result = {{16{raw[15]}}, raw[15:0]};
      3'b100:  load_result = {24'h000000, raw[7:0]};
      3'b101:  load_result = {16'h0000, raw[15:0]};
      default: load_result = raw;
    endcase
  endfunction

  logic [31:0] mem [DEPTH_WORDS];

  state_e      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        phase_q, phase_d;
  logic [AW+1:0] addr_q, addr_d;
  logic [2:0]  size_q, size_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] word0_q, word0_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;

  logic [1:0]    off_s;
  logic [2:0]    n_s;
  logic          cross_s;
  logic [7:0]    be_s;
  logic [31:0]   rot_s;
  logic [AW-1:0] idx_s, acc_idx_s;
  logic [31:0]   rd_word_s;
  logic [2:0]    in_n_s;
  logic          in_err_s;
  logic          wr_en_s;
  logic [3:0]    wr_be_s;

  // Lane steering and word selection derived from the captured request.
  always_comb begin
    off_s   = addr_q[1:0];
    n_s     = size_bytes(size_q[1:0]);
    cross_s = (({1'b0, off_s}) + n_s) > 3'd4;
    case (n_s)
      3'd1:    be_s = 8'b0000_0001 << off_s;
      3'd2:    be_s = 8'b0000_0011 << off_s;
      default: be_s = 8'b0000_1111 << off_s;
    endcase
    case (off_s)
      2'd0:    rot_s = wdata_q;
      2'd1:    rot_s = {wdata_q[23:0], wdata_q[31:24]};
      2'd2:    rot_s = {wdata_q[15:0], wdata_q[31:16]};
      default: rot_s = {wdata_q[7:0],  wdata_q[31:8]};
    endcase
    idx_s = addr_q[AW+1:2];
    if (state_q == S_ACC1) begin
      acc_idx_s = idx_s + AW'(1);
      wr_be_s   = be_s[7:4];
    end else begin
      acc_idx_s = idx_s;
      wr_be_s   = be_s[3:0];
    end
    rd_word_s = mem[acc_idx_s];
    wr_en_s   = we_q && ((state_q == S_ACC0) || (state_q == S_ACC1));
    in_n_s    = size_bytes(req_size[1:0]);
    in_err_s  = size_illegal(req_we, req_size) ||
                (({1'b0, req_addr} + {30'b0, in_n_s}) > MEM_BYTES);
  end

  // Next-state and response computation for the access sequencer.
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    phase_d      = phase_q;
    addr_d       = addr_q;
    size_d       = size_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    word0_d      = word0_q;
    req_ready_d  = 1'b0;
    resp_valid_d = 1'b0;
    resp_rdata_d = 32'h0000_0000;
    resp_err_d   = 1'b0;
    case (state_q)
      S_IDLE, S_RESP: begin
        if (req_valid && req_ready_q) begin
          addr_d  = req_addr[AW+1:0];
          size_d  = req_size;
          we_d    = req_we;
          wdata_d = req_wdata;
          phase_d = 1'b0;
          if (in_err_s) begin
            state_d      = S_RESP;
            req_ready_d  = 1'b1;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (HAS_WAIT) begin
            state_d    = S_WAIT;
            wait_cnt_d = WAIT_LOAD;
          end else begin
            state_d = S_ACC0;
          end
        end else begin
          state_d     = S_IDLE;
          req_ready_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (wait_cnt_q == 4'd0) begin
          state_d = phase_q ? S_ACC1 : S_ACC0;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      S_ACC0: begin
        word0_d = rd_word_s;
        if (cross_s) begin
          phase_d = 1'b1;
          if (HAS_WAIT) begin
            state_d    = S_WAIT;
            wait_cnt_d = WAIT_LOAD;
          end else begin
            state_d = S_ACC1;
          end
        end else begin
          state_d      = S_RESP;
          req_ready_d  = 1'b1;
          resp_valid_d = 1'b1;
          resp_rdata_d = we_q ? 32'h0000_0000 : load_result(32'h0000_0000, rd_word_s, off_s, size_q);
        end
      end
      S_ACC1: begin
        state_d      = S_RESP;
        req_ready_d  = 1'b1;
        resp_valid_d = 1'b1;
        resp_rdata_d = we_q ? 32'h0000_0000 : load_result(rd_word_s, word0_q, off_s, size_q);
      end
      default: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      wait_cnt_q   <= 4'd0;
      phase_q      <= 1'b0;
      addr_q       <= '0;
      size_q       <= 3'b000;
      we_q         <= 1'b0;
      wdata_q      <= 32'h0000_0000;
      word0_q      <= 32'h0000_0000;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0000_0000;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      phase_q      <= phase_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      word0_q      <= word0_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Byte-enabled RAM write; a pending write is dropped while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst && wr_en_s) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be_s[b]) begin
          mem[acc_idx_s][8*b +: 8] <= rot_s[8*b +: 8];
        end
      end
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_mem_responder.sv
`timescale 1ns/1ps
// Bench for mem_responder: two instances (no wait states / three wait states)
// checked against a byte-array reference model.
module tb_mem_responder;

  localparam int DEPTH = 256;
  localparam int MEMB  = DEPTH * 4;

  logic        clk;
  logic        rst;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [31:0] req_addr  [2];
  logic [2:0]  req_size  [2];
  logic [31:0] req_wdata [2];
  logic        resp_valid[2];
  logic [31:0] resp_rdata[2];
  logic        resp_err  [2];

  logic [7:0] mm [2][MEMB];
  int total = 0;
  int bad   = 0;

  mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_size(req_size[0]),
    .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]),
    .resp_err(resp_err[0]));

  mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(3)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_size(req_size[1]),
    .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]),
    .resp_err(resp_err[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  function automatic int waits(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: byte-addressed memory, rules applied directly.
  task automatic model_txn(input int d, input logic we, input logic [31:0] a, input logic [2:0] s,
                           input logic [31:0] wd, output logic e, output logic [31:0] rd, output int lat);
    int n;
    logic [31:0] v;
    n  = (s[1:0] == 2'd0) ? 1 : (s[1:0] == 2'd1) ? 2 : 4;
    e  = (s == 3'd3) || (s == 3'd6) || (s == 3'd7) || (we && s[2]) ||
         ((longint'(a) + longint'(n)) > longint'(MEMB));
    rd = 32'h0;
    if (e) begin
      lat = 1;
    end else begin
      lat = ((int'(a[1:0]) + n) > 4) ? 3 + 2 * waits(d) : 2 + waits(d);
      if (we) begin
        for (int i = 0; i < n; i++) mm[d][int'(a) + i] = wd[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(mm[d][int'(a) + i]) << (8 * i));
        if (s == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
        if (s == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
        rd = v;
      end
    end
  endtask

  task automatic drive(input int d, input logic v, input logic we, input logic [31:0] a,
                       input logic [2:0] s, input logic [31:0] wd);
    req_valid[d] = v;
    req_we[d]    = we;
    req_addr[d]  = a;
    req_size[d]  = s;
    req_wdata[d] = wd;
  endtask

  // Waits for the response after an accept edge; scrambles the idle request fields.
  task automatic wait_resp(input int d, input bit hold_next, input logic nwe, input logic [31:0] na,
                           input logic [2:0] ns, input logic [31:0] nwd, output int lat, output bit got);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 60) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        if (hold_next) drive(d, 1'b1, nwe, na, ns, nwd);
        else drive(d, 1'b0, 1'($urandom), $urandom, 3'($urandom), $urandom);
      end
      if (resp_valid[d]) got = 1'b1;
    end
  endtask

  task automatic check_resp(input string tag, input int d, input bit got, input int lat,
                            input logic ee, input logic [31:0] er, input int el);
    chk({tag, "_seen"}, {31'b0, got}, 32'd1);
    chk({tag, "_err"}, {31'b0, resp_err[d]}, {31'b0, ee});
    chk({tag, "_rdata"}, resp_rdata[d], er);
    chk({tag, "_lat"}, 32'(lat), 32'(el));
  endtask

  task automatic do_txn(input string tag, input int d, input logic we, input logic [31:0] a,
                        input logic [2:0] s, input logic [31:0] wd,
                        output logic [31:0] rd_o, output logic e_o, output int lat_o);
    logic ee; logic [31:0] er; int el; bit got;
    model_txn(d, we, a, s, wd, ee, er, el);
    @(negedge clk);
    chk({tag, "_idle_rdy"}, {31'b0, req_ready[d]}, 32'd1);
    chk({tag, "_idle_vld"}, {31'b0, resp_valid[d]}, 32'd0);
    drive(d, 1'b1, we, a, s, wd);
    @(posedge clk);
    wait_resp(d, 1'b0, 1'b0, 32'h0, 3'd0, 32'h0, lat_o, got);
    rd_o = resp_rdata[d];
    e_o  = resp_err[d];
    check_resp(tag, d, got, lat_o, ee, er, el);
  endtask

  // Second request is held valid while the first is busy; it must be taken in RESP.
  task automatic b2b(input string tag, input int d,
                     input logic awe, input logic [31:0] aa, input logic [2:0] as, input logic [31:0] awd,
                     input logic bwe, input logic [31:0] ba, input logic [2:0] bs, input logic [31:0] bwd,
                     output logic [31:0] brd, output int alat, output int blat);
    logic ae, be; logic [31:0] ar, br; int ael, bel; bit got;
    model_txn(d, awe, aa, as, awd, ae, ar, ael);
    model_txn(d, bwe, ba, bs, bwd, be, br, bel);
    @(negedge clk);
    drive(d, 1'b1, awe, aa, as, awd);
    @(posedge clk);
    wait_resp(d, 1'b1, bwe, ba, bs, bwd, alat, got);
    check_resp({tag, "_a"}, d, got, alat, ae, ar, ael);
    chk({tag, "_rdy_in_resp"}, {31'b0, req_ready[d]}, 32'd1);
    @(posedge clk);
    wait_resp(d, 1'b0, 1'b0, 32'h0, 3'd0, 32'h0, blat, got);
    brd = resp_rdata[d];
    check_resp({tag, "_b"}, d, got, blat, be, br, bel);
  endtask

  initial begin
    logic [31:0] rd;
    logic e;
    int lat, lat2, pulses, r;
    logic we;
    logic [2:0] s;
    logic [31:0] a;
    logic [2:0] size_tab [10];
    size_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd7};

    rst = 1'b0;
    for (int d = 0; d < 2; d++) drive(d, 1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready", {31'b0, req_ready[d]}, 32'd1);
      chk("rst_valid", {31'b0, resp_valid[d]}, 32'd0);
      chk("rst_rdata", resp_rdata[d], 32'd0);
      chk("rst_err",   {31'b0, resp_err[d]}, 32'd0);
    end
    rst = 1'b1;

    // Give every byte a known value.
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < DEPTH; w++)
        do_txn("fill", d, 1'b1, 32'(w * 4), 3'd2, $urandom, rd, e, lat);

    // Directed checks on the zero-wait instance.
    do_txn("st_w", 0, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF, rd, e, lat);
    chk("st_w_lat_c", 32'(lat), 32'd2);
    do_txn("ld_w", 0, 1'b0, 32'h10, 3'd2, 32'h0, rd, e, lat);
    chk("ld_w_c", rd, 32'hDEADBEEF);
    do_txn("ld_b", 0, 1'b0, 32'h13, 3'd0, 32'h0, rd, e, lat);
    chk("ld_b_c", rd, 32'hFFFFFFDE);
    do_txn("ld_bu", 0, 1'b0, 32'h13, 3'd4, 32'h0, rd, e, lat);
    chk("ld_bu_c", rd, 32'h000000DE);
    do_txn("ld_hu", 0, 1'b0, 32'h12, 3'd5, 32'h0, rd, e, lat);
    chk("ld_hu_c", rd, 32'h0000DEAD);
    do_txn("st20", 0, 1'b1, 32'h20, 3'd2, 32'h44332211, rd, e, lat);
    do_txn("st24", 0, 1'b1, 32'h24, 3'd2, 32'h88776655, rd, e, lat);
    do_txn("st_hx", 0, 1'b1, 32'h23, 3'd1, 32'h0000AABB, rd, e, lat);
    chk("st_hx_lat_c", 32'(lat), 32'd3);
    do_txn("ld20", 0, 1'b0, 32'h20, 3'd2, 32'h0, rd, e, lat);
    chk("ld20_c", rd, 32'hBB332211);
    do_txn("ld24", 0, 1'b0, 32'h24, 3'd2, 32'h0, rd, e, lat);
    chk("ld24_c", rd, 32'h887766AA);
    do_txn("ld22", 0, 1'b0, 32'h22, 3'd2, 32'h0, rd, e, lat);
    chk("ld22_c", rd, 32'h66AABB33);
    do_txn("err_top", 0, 1'b0, 32'(MEMB - 2), 3'd2, 32'h0, rd, e, lat);
    chk("err_top_c", {31'b0, e}, 32'd1);
    chk("err_top_lat_c", 32'(lat), 32'd1);
    do_txn("err_sbu", 0, 1'b1, 32'h10, 3'd4, 32'h12345678, rd, e, lat);
    chk("err_sbu_c", {31'b0, e}, 32'd1);
    do_txn("ld_after_sbu", 0, 1'b0, 32'h10, 3'd2, 32'h0, rd, e, lat);
    chk("ld_after_sbu_c", rd, 32'hDEADBEEF);
    do_txn("err_sz7", 0, 1'b0, 32'h40, 3'd7, 32'h0, rd, e, lat);
    chk("err_sz7_c", {31'b0, e}, 32'd1);
    do_txn("ld_lastb", 0, 1'b0, 32'(MEMB - 1), 3'd4, 32'h0, rd, e, lat);
    do_txn("err_lasth", 0, 1'b0, 32'(MEMB - 1), 3'd1, 32'h0, rd, e, lat);
    b2b("b2b_err", 0, 1'b0, 32'h0, 3'd6, 32'h0, 1'b0, 32'h20, 3'd2, 32'h0, rd, lat, lat2);

    // Wait-state instance: latency and back-to-back with read-after-write.
    do_txn("w3_ld", 1, 1'b0, 32'h10, 3'd2, 32'h0, rd, e, lat);
    chk("w3_ld_lat_c", 32'(lat), 32'd5);
    do_txn("w3_ldx", 1, 1'b0, 32'h22, 3'd2, 32'h0, rd, e, lat);
    chk("w3_ldx_lat_c", 32'(lat), 32'd9);
    b2b("w3_b2b", 1, 1'b1, 32'h23, 3'd1, 32'h0000AABB, 1'b0, 32'h22, 3'd2, 32'h0, rd, lat, lat2);
    chk("w3_b2b_lat_a", 32'(lat), 32'd9);
    chk("w3_b2b_lat_b", 32'(lat2), 32'd9);

    // Randomized traffic on both instances.
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 150; k++) begin
        we = 1'($urandom_range(0, 1));
        s  = size_tab[$urandom_range(0, 9)];
        r  = $urandom_range(0, 7);
        if (r == 0)      a = 32'(MEMB - 8 + $urandom_range(0, 11));
        else if (r == 1) a = $urandom;
        else             a = 32'($urandom_range(0, MEMB - 1));
        if (k % 10 == 9)
          b2b("rnd_b2b", d, we, a, s, $urandom, 1'b0, a, 3'd2, 32'h0, rd, lat, lat2);
        else
          do_txn("rnd", d, we, a, s, $urandom, rd, e, lat);
      end
    end

    // Reset during the second word write of a crossing store.
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'h41, 3'd2, 32'hA1B2C3D4);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
    chk("rstx_busy_rdy", {31'b0, req_ready[0]}, 32'd0);
    @(negedge clk);
    chk("rstx_acc1_vld", {31'b0, resp_valid[0]}, 32'd0);
    rst = 1'b0;
    pulses = 0;
    repeat (2) begin @(negedge clk); pulses += int'(resp_valid[0]); end
    rst = 1'b1;
    repeat (6) begin @(negedge clk); pulses += int'(resp_valid[0]); end
    chk("rstx_no_resp", 32'(pulses), 32'd0);
    chk("rstx_rdy", {31'b0, req_ready[0]}, 32'd1);
    mm[0][32'h41] = 8'hD4;
    mm[0][32'h42] = 8'hC3;
    mm[0][32'h43] = 8'hB2;
    do_txn("rstx_w0", 0, 1'b0, 32'h40, 3'd2, 32'h0, rd, e, lat);
    do_txn("rstx_w1", 0, 1'b0, 32'h44, 3'd2, 32'h0, rd, e, lat);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
